// File: rtl/decade_ctr.sv
// Single BCD digit counter: up/down count, synchronous load with out-of-range clamp,
// and a combinational terminal-count carry for cascading digits.
module decade_ctr (
  input  logic       sys_clk,
  input  logic       up_dn,
  input  logic       cnt_en,
  input  logic       reset_n,
  input  logic       load,
  input  logic [3:0] load_val,
  output logic [3:0] count,
  output logic       carry
);

  logic [3:0] count_r;
  logic [3:0] count_nxt_s;
  logic       carry_s;

  function automatic logic [3:0] bcd_clamp(input logic [3:0] v);
    if (v <= 4'd9) begin
      bcd_clamp = v;
    end else begin
      bcd_clamp = 4'd0;
    end
  endfunction

  // Any value at or above 9 wraps to 0 so the digit can never leave 0-9.
  function automatic logic [3:0] bcd_inc(input logic [3:0] v);
    if (v >= 4'd9) begin
      bcd_inc = 4'd0;
    end else begin
      bcd_inc = v + 4'd1;
    end
  endfunction

  function automatic logic [3:0] bcd_dec(input logic [3:0] v);
    if ((v == 4'd0) || (v > 4'd9)) begin
      bcd_dec = 4'd9;
    end else begin
      bcd_dec = v - 4'd1;
    end
  endfunction

  // Next-count selection: load beats counting, counting beats hold.
  always_comb begin
    count_nxt_s = count_r;
    if (load) begin
      count_nxt_s = bcd_clamp(load_val);
    end else if (cnt_en) begin
      if (up_dn) begin
        count_nxt_s = bcd_inc(count_r);
      end else begin
        count_nxt_s = bcd_dec(count_r);
      end
    end else begin
      count_nxt_s = count_r;
    end
  end

  // Terminal count: high in the cycle whose next edge wraps the digit.
  always_comb begin
    carry_s = 1'b0;
    if (cnt_en && !load) begin
      if (up_dn) begin
        carry_s = (count_r == 4'd9);
      end else begin
        carry_s = (count_r == 4'd0);
      end
    end else begin
      carry_s = 1'b0;
    end
  end

  // Digit register with asynchronous clear.
  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) begin
      count_r <= 4'd0;
    end else begin
      count_r <= count_nxt_s;
    end
  end

  assign count = count_r;
  assign carry = carry_s;

endmodule

// File: tb/tb_decade_ctr.sv
// Randomized scoreboard bench for decade_ctr plus a two-digit cascade check.
module tb_decade_ctr;

  logic       sys_clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       up_dn = 1'b0;
  logic       cnt_en = 1'b0;
  logic       load = 1'b0;
  logic [3:0] load_val = 4'd0;
  logic [3:0] count;
  logic       carry;

  logic       ch_rst_n = 1'b0;
  logic       ch_tff = 1'b0;
  logic [3:0] lo_count;
  logic [3:0] hi_count;
  logic       lo_carry;
  logic       hi_carry;

  typedef struct {
    logic [3:0] cnt;
    logic       cry;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   model = 0;
  int   carry_rises = 0;
  bit   stim_done = 1'b0;
  bit   mon_done = 1'b0;

  always #5 sys_clk = ~sys_clk;

  decade_ctr dut (
    .sys_clk (sys_clk),
    .up_dn   (up_dn),
    .cnt_en  (cnt_en),
    .reset_n (reset_n),
    .load    (load),
    .load_val(load_val),
    .count   (count),
    .carry   (carry)
  );

  decade_ctr u_lo (
    .sys_clk (sys_clk),
    .up_dn   (1'b1),
    .cnt_en  (1'b1),
    .reset_n (ch_rst_n),
    .load    (1'b0),
    .load_val(4'd0),
    .count   (lo_count),
    .carry   (lo_carry)
  );

  decade_ctr u_hi (
    .sys_clk (ch_tff),
    .up_dn   (1'b1),
    .cnt_en  (1'b1),
    .reset_n (ch_rst_n),
    .load    (1'b0),
    .load_val(4'd0),
    .count   (hi_count),
    .carry   (hi_carry)
  );

  always @(posedge lo_carry or negedge lo_carry or negedge ch_rst_n) begin
    if (!ch_rst_n) ch_tff <= 1'b0;
    else           ch_tff <= ~ch_tff;
  end

  always @(posedge carry) carry_rises++;

  task automatic check_val(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  // One cycle of stimulus; the reference digit is plain modulo-10 arithmetic.
  task automatic step(input bit up, input bit en, input bit ld, input logic [3:0] lv,
                      input bit rst_pulse, input bit rst_hold);
    exp_t e;
    @(negedge sys_clk);
    #1;
    if (rst_pulse) begin
      reset_n = 1'b0;
      #1;
      check_val("async_reset", {28'd0, count}, 32'd0);
      reset_n = 1'b1;
      model = 0;
    end
    reset_n = rst_hold ? 1'b0 : 1'b1;
    if (rst_hold) model = 0;
    up_dn = up; cnt_en = en; load = ld; load_val = lv;
    e.cnt = 4'(model);
    e.cry = en && !ld && (up ? (model == 9) : (model == 0));
    exp_q.push_back(e);
    if (rst_hold)  model = 0;
    else if (ld)   model = (int'(lv) <= 9) ? int'(lv) : 0;
    else if (en)   model = up ? (model + 1) % 10 : (model + 9) % 10;
  endtask

  // Monitor: compares the DUT against the oldest expectation each cycle.
  initial begin
    exp_t e;
    int   idle = 0;
    forever begin
      @(negedge sys_clk);
      #3;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check_val("count", {28'd0, count}, {28'd0, e.cnt});
        check_val("carry", {31'd0, carry}, {31'd0, e.cry});
        idle = 0;
      end else if (stim_done) begin
        break;
      end else begin
        idle++;
        if (idle > 200) begin
          errors++;
          $display("FAIL monitor_timeout actual=%0d required=%0d", idle, 0);
          break;
        end
      end
    end
    mon_done = 1'b1;
  end

  initial begin
    int r0;
    int wait_cyc;
    int n;

    step(1'b1, 1'b1, 1'b0, 4'd0, 1'b0, 1'b1);
    step(1'b0, 1'b1, 1'b0, 4'd0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b1);
    repeat (5) step(1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0);

    r0 = carry_rises;
    repeat (12) step(1'b1, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0);
    check_val("carry_rises_per_wrap", carry_rises - r0, 1);

    step(1'b1, 1'b0, 1'b1, 4'd0, 1'b0, 1'b0);
    repeat (11) step(1'b0, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0);

    step(1'b1, 1'b1, 1'b1, 4'd7, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b1, 4'd12, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b1, 4'd15, 1'b0, 1'b0);

    step(1'b1, 1'b0, 1'b1, 4'd5, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 4'd0, 1'b1, 1'b0);
    repeat (3) step(1'b1, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0);

    for (int i = 0; i < 300; i++) begin
      step($urandom_range(1, 0) == 1, $urandom_range(3, 0) != 0, $urandom_range(4, 0) == 0,
           4'($urandom_range(15, 0)), $urandom_range(31, 0) == 0, $urandom_range(31, 0) == 0);
    end
    step(1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
    stim_done = 1'b1;

    wait_cyc = 0;
    while (!mon_done && wait_cyc < 100) begin
      @(posedge sys_clk);
      wait_cyc++;
    end
    if (!mon_done) begin
      errors++;
      $display("FAIL drain_timeout actual=%0d required=%0d", exp_q.size(), 0);
    end

    // Cascade: two digits from reset, 25 clocks should read BCD 25.
    @(negedge sys_clk);
    #1;
    check_val("chain_reset", {24'd0, hi_count, lo_count}, 32'd0);
    ch_rst_n = 1'b1;
    n = 25;
    repeat (n) @(posedge sys_clk);
    #1;
    check_val("chain_25", {24'd0, hi_count, lo_count}, ((n / 10) << 4) | (n % 10));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=%0d required=%0d", checks, 0);
    $fatal(1);
  end

endmodule
